logic_unit_acc: RTL and testbench

Parametrised, registered bitwise logic unit: the generalised successor of the fixed 16-bit combinational OR. It supports eight bitwise operations, WIDTH-bit operands, a valid/ready handshake on both sides, and a multi-beat accumulate mode that folds a burst of operands into one result. It sits between the register file read path and the write-back mux as the logic half of the ALU, and sustains one result per cycle under no backpressure.

---
 rtl/logic_unit_acc.sv | 123 ++++++++++++
 tb/tb_logic_unit_acc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_acc.sv
// Registered bitwise logic unit with valid/ready on both sides and a multi-beat accumulate mode.
// Latency 1 cycle; in_ready = !out_valid || out_ready, so a stalled result blocks new beats.
module logic_unit_acc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ones_q, out_ones_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             accept, emit;
  logic [WIDTH-1:0] x, r;
  logic [CNT_W-1:0] cnt_base, cnt_inc;

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    accept = in_valid && in_ready;
    emit   = out_valid_q && out_ready;

    // The accumulator only stands in for operand A while a burst is open.
    x = (state_q == ACCUM && in_acc) ? acc_q : in_a;

    r = ~x;
    case (in_op)
      3'd0: r = x & in_b;
      3'd1: r = x | in_b;
      3'd2: r = x ^ in_b;
      3'd3: r = ~(x & in_b);
      3'd4: r = ~(x | in_b);
      3'd5: r = ~(x ^ in_b);
      3'd6: r = x & ~in_b;
      3'd7: r = ~x;
      default: r = ~x;
    endcase

    cnt_base = (state_q == ACCUM) ? cnt_q : '0;
    cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    out_ones_d  = out_ones_q;
    out_count_d = out_count_q;

    if (emit) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = r;
        out_zero_d  = (r == '0);
        out_ones_d  = &r;
        out_count_d = cnt_inc;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = IDLE;
      end else begin
        acc_d   = r;
        cnt_d   = cnt_inc;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_ones_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_ones_q  <= out_ones_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_ones  = out_ones_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_logic_unit_acc.sv
// Scoreboard bench: three widths (16, 1, 32) run in lockstep from shared 32-bit stimulus.
module tb_logic_unit_acc;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_acc = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy16, ov16, z16, o16;
  logic [15:0] d16;
  logic [7:0]  c16;
  logic        rdy1, ov1, z1, o1;
  logic [0:0]  d1;
  logic [7:0]  c1;
  logic        rdy32, ov32, z32, o32;
  logic [31:0] d32;
  logic [7:0]  c32;

  logic_unit_acc #(.WIDTH(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_op(in_op),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_acc(in_acc), .in_last(in_last),
    .out_valid(ov16), .out_ready(out_ready), .out_data(d16), .out_zero(z16),
    .out_ones(o16), .out_count(c16));

  logic_unit_acc #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .in_acc(in_acc), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_zero(z1),
    .out_ones(o1), .out_count(c1));

  logic_unit_acc #(.WIDTH(32), .CNT_W(8)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_last(in_last),
    .out_valid(ov32), .out_ready(out_ready), .out_data(d32), .out_zero(z32),
    .out_ones(o32), .out_count(c32));

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_push = 0;
  int   n_emit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: checks handshake, pops the scoreboard on every emit, and checks hold stability.
  exp_t        e;
  logic [15:0] e16;
  logic        held_prev = 1'b0;
  logic [15:0] h_d;
  logic [7:0]  h_c;
  logic        h_z, h_o;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      held_prev = 1'b0;
    end else begin
      chk("in_ready", rdy16, !ov16 || out_ready);
      chk("ov_w1_lockstep", ov1, ov16);
      chk("ov_w32_lockstep", ov32, ov16);
      if (ov16 && out_ready) begin
        n_emit++;
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e   = sb.pop_front();
          e16 = e.data[15:0];
          chk("d16", d16, e16);
          chk("z16", z16, e16 == 16'h0);
          chk("o16", o16, &e16);
          chk("c16", c16, e.cnt);
          chk("d32", d32, e.data);
          chk("z32", z32, e.data == 32'h0);
          chk("o32", o32, &e.data);
          chk("c32", c32, e.cnt);
          chk("d1", d1, e.data[0]);
          chk("z1", z1, !e.data[0]);
          chk("o1", o1, e.data[0]);
          chk("c1", c1, e.cnt);
        end
      end
      if (ov16 && !out_ready) begin
        chk("hold_in_ready", rdy16, 0);
        if (held_prev) begin
          chk("hold_data", d16, h_d);
          chk("hold_count", c16, h_c);
          chk("hold_flags", {z16, o16}, {h_z, h_o});
        end
        held_prev = 1'b1;
        h_d = d16; h_c = c16; h_z = z16; h_o = o16;
      end else begin
        held_prev = 1'b0;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic acc, input logic last);
    bit ok;
    ok = 0;
    in_op = op; in_a = a; in_b = b; in_acc = acc; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy16) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic last_beat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic acc, input logic [31:0] exp_d, input logic [7:0] exp_c);
    exp_t x;
    x.data = exp_d;
    x.cnt  = exp_c;
    sb.push_back(x);
    n_push++;
    send(op, a, b, acc, 1'b1);
  endtask

  function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] b);
    case (op)
      3'd0: return x & b;
      3'd1: return x | b;
      3'd2: return x ^ b;
      3'd3: return ~(x & b);
      3'd4: return ~(x | b);
      3'd5: return ~(x ^ b);
      3'd6: return x & ~b;
      default: return ~x;
    endcase
  endfunction

  bit done = 0;

  initial begin
    // Asynchronous reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    chk("rst_ov", {ov16, ov1, ov32}, 0);
    chk("rst_data", {d16, d1, d32}, 0);
    chk("rst_flags", {z16, o16, z1, o1, z32, o32}, 0);
    chk("rst_count", {c16, c1, c32}, 0);
    chk("rst_in_ready", {rdy16, rdy1, rdy32}, 3'b111);
    #5 clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Single beats, back to back.
    last_beat(3'd1, 32'h0000, 32'hFFFF, 1'b0, 32'h0000FFFF, 8'd1);
    last_beat(3'd1, 32'hFFFF, 32'h00FF, 1'b0, 32'h0000FFFF, 8'd1);
    last_beat(3'd2, 32'hA5A5, 32'hA5A5, 1'b0, 32'h00000000, 8'd1);

    // Accumulate burst; in_a is a decoy once the accumulator is selected.
    send(3'd1, 32'h0001, 32'h0000, 1'b0, 1'b0);
    send(3'd1, 32'hF000, 32'h0010, 1'b1, 1'b0);
    last_beat(3'd1, 32'hF000, 32'h0100, 1'b1, 32'h00000111, 8'd3);

    // Backpressure: first result stalls 5 cycles, then emit and new accept coincide.
    @(posedge clk); #1;
    out_ready = 1'b0;
    last_beat(3'd1, 32'h00FF, 32'h0000, 1'b0, 32'h000000FF, 8'd1);
    fork
      last_beat(3'd1, 32'h0F0F, 32'hF000, 1'b0, 32'h0000FF0F, 8'd1);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("b2b_out_valid", ov16, 1);
    chk("b2b_data", d16, 16'hFF0F);

    // Reset mid-burst discards the burst; in_acc is then ignored in IDLE.
    send(3'd1, 32'h1111, 32'h0000, 1'b0, 1'b0);
    send(3'd1, 32'h2222, 32'h0000, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    chk("midrst_in_ready", rdy16, 1);
    chk("midrst_ov", ov16, 0);
    @(posedge clk); #1 rst = 1'b0;
    last_beat(3'd7, 32'h1234, 32'h0000, 1'b1, 32'hFFFFEDCB, 8'd1);

    // 300-beat burst saturates the count.
    send(3'd1, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 298; i++) send(3'd1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    last_beat(3'd1, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h00000001, 8'd255);

    // All ops with random operands, random in_acc and random backpressure.
    fork
      begin
        logic [31:0] m_acc, a, b, x, r;
        logic [7:0]  m_cnt, nc;
        bit          m_open, acc, last;
        m_acc = '0; m_cnt = '0; m_open = 0;
        for (int op = 0; op < 8; op++) begin
          for (int k = 0; k < 6; k++) begin
            a = $urandom; b = $urandom;
            acc  = ($urandom_range(0, 1) == 1);
            last = (k == 2 || k == 5);
            x  = (m_open && acc) ? m_acc : a;
            r  = model_op(op[2:0], x, b);
            nc = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
            if (last) begin
              last_beat(op[2:0], a, b, acc, r, nc);
              m_acc = '0; m_cnt = '0; m_open = 0;
            end else begin
              send(op[2:0], a, b, acc, 1'b0);
              m_acc = r; m_cnt = nc; m_open = 1;
            end
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", sb.size(), 0);
    chk("emit_count", n_emit, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
